// File: rtl/cabac_pkg.sv
// Shared CABAC decoder types and widths used by the bypass-bin bitstream feeder.
package cabac_pkg;

    localparam int EP_MAX_BINS = 3;
    localparam int VALUE_W     = 16;
    localparam int ADDEND_W    = 17;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_LOAD_HI = 2'd1,
        FS_LOAD_LO = 2'd2,
        FS_RUN     = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/ep_bit_buffer.sv
// MSB-aligned stream bit buffer: bit k of the stream sits at buf_q[BUF_W-1-k].
// Bits at or beyond bit_cnt are always zero, so a new byte can be OR-ed into place.
module ep_bit_buffer #(
    parameter int BUF_W = 24,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             consume_en,
    input  logic [1:0]       consume_n,
    input  logic             insert_en,
    input  logic [7:0]       insert_byte,
    output logic [BUF_W-1:0] buf_q,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] ins_vec;
    logic [BUF_W-1:0] buf_d;
    logic [CNT_W-1:0] cnt_after;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        shifted   = buf_q;
        cnt_after = bit_cnt;
        ins_vec   = '0;
        if (consume_en) begin
            shifted   = buf_q << consume_n;
            cnt_after = bit_cnt - CNT_W'(consume_n);
        end
        // The incoming byte lands right after whatever survives this cycle's consume.
        if (insert_en) begin
            ins_vec = {insert_byte, {(BUF_W-8){1'b0}}} >> cnt_after;
        end
        buf_d = shifted | ins_vec;
        cnt_d = cnt_after + (insert_en ? CNT_W'(8) : CNT_W'(0));
        if (flush) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            bit_cnt <= '0;
        end else begin
            buf_q   <= buf_d;
            bit_cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/ep_bit_feeder.sv
// Bitstream feeder for the bypass bin decoder: owns the 16-bit value register
// and presents the next 1..3 stream bits as addends for a multi-bin EP decode.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | after reset, waiting for init
// LOAD_HI | taking first slice byte into m_value[15:8]
// LOAD_LO | taking second slice byte into m_value[7:0]
// RUN     | filling bit buffer, serving EP decode requests
module ep_bit_feeder
    import cabac_pkg::*;
#(
    parameter int BUF_W    = 24,
    parameter int MAX_BINS = EP_MAX_BINS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic [VALUE_W-1:0]  m_value,
    output logic [ADDEND_W-1:0] new_m_value_in0,
    output logic [ADDEND_W-1:0] new_m_value_in1,
    output logic [ADDEND_W-1:0] new_m_value_in2,
    input  logic                ep_valid,
    input  logic [1:0]          n_bin,
    input  logic [VALUE_W-1:0]  m_value_upd,
    output logic                ep_ready,
    output logic [4:0]          bit_cnt
);

    localparam int CNT_W = 5;

    feeder_state_t    state;
    logic [BUF_W-1:0] buf_q;
    logic             ep_accept;
    logic             buf_insert;
    logic [1:0]       consume_n;
    logic [CNT_W-1:0] need_bits;

    assign need_bits = CNT_W'(n_bin) + CNT_W'(1);
    assign consume_n = n_bin + 2'd1;

    always_comb begin
        byte_ready = 1'b0;
        unique case (state)
            FS_LOAD_HI, FS_LOAD_LO: byte_ready = 1'b1;
            FS_RUN:                 byte_ready = (bit_cnt <= CNT_W'(BUF_W - 8));
            default:                byte_ready = 1'b0;
        endcase
    end

    // n_bin beyond MAX_BINS-1 is never servable, regardless of buffer fill.
    assign ep_ready = (state == FS_RUN)
                   && (CNT_W'(n_bin) < CNT_W'(MAX_BINS))
                   && (bit_cnt >= need_bits);

    assign ep_accept  = ep_valid && ep_ready && !init;
    assign buf_insert = byte_valid && byte_ready && (state == FS_RUN) && !init;

    ep_bit_buffer #(
        .BUF_W (BUF_W),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (init),
        .consume_en  (ep_accept),
        .consume_n   (consume_n),
        .insert_en   (buf_insert),
        .insert_byte (byte_in),
        .buf_q       (buf_q),
        .bit_cnt     (bit_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FS_IDLE;
            m_value <= '0;
        end else if (init) begin
            state <= FS_LOAD_HI;
        end else begin
            unique case (state)
                FS_IDLE: begin
                    state <= FS_IDLE;
                end
                FS_LOAD_HI: begin
                    if (byte_valid) begin
                        m_value[15:8] <= byte_in;
                        state         <= FS_LOAD_LO;
                    end
                end
                FS_LOAD_LO: begin
                    if (byte_valid) begin
                        m_value[7:0] <= byte_in;
                        state        <= FS_RUN;
                    end
                end
                FS_RUN: begin
                    if (ep_accept) begin
                        m_value <= m_value_upd;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

    // Addends past the valid fill are forced to zero so they are deterministic.
    assign new_m_value_in0 = {{(ADDEND_W-1){1'b0}}, (bit_cnt > CNT_W'(0)) & buf_q[BUF_W-1]};
    assign new_m_value_in1 = {{(ADDEND_W-1){1'b0}}, (bit_cnt > CNT_W'(1)) & buf_q[BUF_W-2]};
    assign new_m_value_in2 = {{(ADDEND_W-1){1'b0}}, (bit_cnt > CNT_W'(2)) & buf_q[BUF_W-3]};

    a_nbin_legal: assert property (@(posedge clk) disable iff (!rst_n)
        ep_valid |-> (n_bin != 2'd3));

endmodule

// File: tb/tb_ep_bit_feeder.sv
// Directed vector bench for ep_bit_feeder: table of cycle records plus a few
// hand-written sequences for reset, ignored requests and buffer saturation.
module tb_ep_bit_feeder;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] m_value;
    logic [16:0] new_m_value_in0;
    logic [16:0] new_m_value_in1;
    logic [16:0] new_m_value_in2;
    logic        ep_valid;
    logic [1:0]  n_bin;
    logic [15:0] m_value_upd;
    logic        ep_ready;
    logic [4:0]  bit_cnt;

    int checks;
    int failures;

    ep_bit_feeder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .init            (init),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .m_value         (m_value),
        .new_m_value_in0 (new_m_value_in0),
        .new_m_value_in1 (new_m_value_in1),
        .new_m_value_in2 (new_m_value_in2),
        .ep_valid        (ep_valid),
        .n_bin           (n_bin),
        .m_value_upd     (m_value_upd),
        .ep_ready        (ep_ready),
        .bit_cnt         (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        init;
        logic        bv;
        logic [7:0]  byte_v;
        logic        ev;
        logic [1:0]  nb;
        logic [15:0] upd;
        logic        exp_br;
        logic        exp_er;
        logic [15:0] exp_m;
        logic [4:0]  exp_cnt;
        logic [2:0]  exp_add;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(logic i, logic bv, logic [7:0] b, logic ev, logic [1:0] nb,
                                logic [15:0] upd, logic br, logic er, logic [15:0] m,
                                logic [4:0] cnt, logic [2:0] add);
        vec_t v;
        v.init = i; v.bv = bv; v.byte_v = b; v.ev = ev; v.nb = nb; v.upd = upd;
        v.exp_br = br; v.exp_er = er; v.exp_m = m; v.exp_cnt = cnt; v.exp_add = add;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] addends();
        return {new_m_value_in2[0], new_m_value_in1[0], new_m_value_in0[0]};
    endfunction

    task automatic check_upper_zero();
        chk("addend_upper", {new_m_value_in2[16:1], new_m_value_in1[16:1], new_m_value_in0[16:1]} == '0, 1);
    endtask

    task automatic drive(logic i, logic bv, logic [7:0] b, logic ev, logic [1:0] nb, logic [15:0] upd);
        init = i; byte_valid = bv; byte_in = b; ep_valid = ev; n_bin = nb; m_value_upd = upd;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(0, 0, 8'h00, 0, 2'd0, 16'h0000);

        //       init bv byte  ev nb    upd      br er m        cnt    add
        tbl[0]  = mk(1, 0, 8'h00, 0, 2'd0, 16'h0000, 0, 0, 16'h0000, 5'd0,  3'b000);
        tbl[1]  = mk(0, 1, 8'hA5, 0, 2'd0, 16'h0000, 1, 0, 16'hA500, 5'd0,  3'b000);
        tbl[2]  = mk(0, 1, 8'h3C, 0, 2'd0, 16'h0000, 1, 0, 16'hA53C, 5'd0,  3'b000);
        tbl[3]  = mk(0, 0, 8'h00, 0, 2'd0, 16'h0000, 1, 0, 16'hA53C, 5'd0,  3'b000);
        tbl[4]  = mk(0, 1, 8'hB0, 0, 2'd2, 16'h0000, 1, 0, 16'hA53C, 5'd8,  3'b101);
        tbl[5]  = mk(0, 0, 8'h00, 1, 2'd2, 16'h1234, 1, 1, 16'h1234, 5'd5,  3'b001);
        tbl[6]  = mk(0, 0, 8'h00, 1, 2'd2, 16'h0001, 1, 1, 16'h0001, 5'd2,  3'b000);
        tbl[7]  = mk(0, 1, 8'hC3, 1, 2'd2, 16'hDEAD, 1, 0, 16'h0001, 5'd10, 3'b100);
        tbl[8]  = mk(0, 0, 8'h00, 1, 2'd2, 16'h0002, 1, 1, 16'h0002, 5'd7,  3'b001);
        tbl[9]  = mk(0, 1, 8'h5A, 1, 2'd2, 16'h0003, 1, 1, 16'h0003, 5'd12, 3'b100);
        tbl[10] = mk(0, 0, 8'h00, 1, 2'd2, 16'h0004, 1, 1, 16'h0004, 5'd9,  3'b101);
        tbl[11] = mk(0, 0, 8'h00, 1, 2'd0, 16'h0005, 1, 1, 16'h0005, 5'd8,  3'b010);
        tbl[12] = mk(0, 1, 8'hE1, 1, 2'd0, 16'h0006, 1, 1, 16'h0006, 5'd15, 3'b101);
        tbl[13] = mk(0, 0, 8'h00, 0, 2'd3, 16'h0000, 1, 0, 16'h0006, 5'd15, 3'b101);
        tbl[14] = mk(0, 1, 8'hFF, 0, 2'd0, 16'h0000, 1, 1, 16'h0006, 5'd23, 3'b101);
        tbl[15] = mk(0, 1, 8'hFF, 0, 2'd0, 16'h0000, 0, 1, 16'h0006, 5'd23, 3'b101);
        tbl[16] = mk(0, 0, 8'h00, 1, 2'd2, 16'h0007, 0, 1, 16'h0007, 5'd20, 3'b101);
        tbl[17] = mk(0, 0, 8'h00, 1, 2'd2, 16'h0008, 0, 1, 16'h0008, 5'd17, 3'b110);
        tbl[18] = mk(0, 1, 8'hFF, 1, 2'd0, 16'h0009, 0, 1, 16'h0009, 5'd16, 3'b111);
        tbl[19] = mk(0, 1, 8'h00, 0, 2'd0, 16'h0000, 1, 1, 16'h0009, 5'd24, 3'b111);
        tbl[20] = mk(1, 1, 8'h11, 1, 2'd0, 16'hBEEF, 0, 1, 16'h0009, 5'd0,  3'b000);
        tbl[21] = mk(0, 1, 8'h77, 0, 2'd0, 16'h0000, 1, 0, 16'h7709, 5'd0,  3'b000);
        tbl[22] = mk(0, 1, 8'h88, 0, 2'd0, 16'h0000, 1, 0, 16'h7788, 5'd0,  3'b000);
        tbl[23] = mk(0, 1, 8'hF0, 0, 2'd0, 16'h0000, 1, 0, 16'h7788, 5'd8,  3'b111);
        tbl[24] = mk(0, 0, 8'h00, 1, 2'd1, 16'h4444, 1, 1, 16'h4444, 5'd6,  3'b011);

        repeat (2) @(negedge clk);
        chk("rst_m_value", m_value, 16'h0000);
        chk("rst_bit_cnt", bit_cnt, 5'd0);
        chk("rst_byte_ready", byte_ready, 1'b0);
        chk("rst_ep_ready", ep_ready, 1'b0);
        chk("rst_addends", addends(), 3'b000);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(tbl[i].init, tbl[i].bv, tbl[i].byte_v, tbl[i].ev, tbl[i].nb, tbl[i].upd);
            #1;
            chk($sformatf("v%0d_byte_ready", i), byte_ready, tbl[i].exp_br);
            chk($sformatf("v%0d_ep_ready", i), ep_ready, tbl[i].exp_er);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_m_value", i), m_value, tbl[i].exp_m);
            chk($sformatf("v%0d_bit_cnt", i), bit_cnt, tbl[i].exp_cnt);
            chk($sformatf("v%0d_addends", i), addends(), tbl[i].exp_add);
            check_upper_zero();
        end

        // Async reset in the middle of a RUN cycle with a request pending.
        @(negedge clk);
        drive(0, 1, 8'hAA, 1, 2'd0, 16'h5555);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_value", m_value, 16'h0000);
        chk("arst_bit_cnt", bit_cnt, 5'd0);
        chk("arst_addends", addends(), 3'b000);
        chk("arst_byte_ready", byte_ready, 1'b0);
        chk("arst_ep_ready", ep_ready, 1'b0);

        // Requests outside RUN are ignored.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_ep_ready", ep_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("idle_m_value", m_value, 16'h0000);
        chk("idle_bit_cnt", bit_cnt, 5'd0);

        // Saturation: continuous 0xFF bytes never overfill the buffer.
        @(negedge clk);
        drive(1, 0, 8'h00, 0, 2'd0, 16'h0000);
        @(negedge clk);
        drive(0, 1, 8'h12, 0, 2'd0, 16'h0000);
        @(negedge clk);
        drive(0, 1, 8'h34, 0, 2'd0, 16'h0000);
        @(negedge clk);
        chk("sat_m_value", m_value, 16'h1234);
        begin
            int exp_cnt;
            exp_cnt = 0;
            drive(0, 1, 8'hFF, 0, 2'd0, 16'h0000);
            for (int c = 0; c < 6; c++) begin
                #1;
                chk($sformatf("sat%0d_byte_ready", c), byte_ready, (exp_cnt <= 16) ? 1'b1 : 1'b0);
                @(posedge clk);
                #1;
                if (exp_cnt <= 16) exp_cnt += 8;
                chk($sformatf("sat%0d_bit_cnt", c), bit_cnt, exp_cnt[4:0]);
                @(negedge clk);
            end
            chk("sat_addends", addends(), 3'b111);
        end
        drive(0, 0, 8'h00, 0, 2'd0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
